ej32_boot_loader: RTL and testbench

Parametrised ROM-to-RAM boot image loader for the eJ32 core. It replaces the inline byte-wide copy-at-reset with a standalone unit that adds the following:
- configurable beat width
- ROM read latency pipeline
- RAM base offset and partial-beat masking
- hold/stall input
- software re-boot request

---
 rtl/ej32_boot_loader.sv | 168 ++++++++++++++++
 tb/tb_ej32_boot_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ej32_boot_loader.sv
// eJ32 boot loader: copies a ROM image into RAM one beat at a time, then releases the core.
// Optional feature macro BOOT_CHKSUM_EN: byte checksum of the image gates core_en.
module ej32_boot_loader #(
  parameter int             ASZ        = 17,
  parameter int             BEAT_BYTES = 1,
  parameter int             ROM_SZ     = 8192,
  parameter int             ROM_WAIT   = 3,
  parameter int             RD_LAT     = 1,
  parameter logic [ASZ-1:0] RAM_BASE   = '0,
  parameter logic [ASZ-1:0] COLD       = '0,
  parameter logic [31:0]    CHK_EXP    = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    hold,
  output logic                    rom_en,
  output logic [ASZ-1:0]          rom_a,
  input  logic [8*BEAT_BYTES-1:0] rom_d,
  output logic                    ram_we,
  output logic [BEAT_BYTES-1:0]   ram_wm,
  output logic [ASZ-1:0]          ram_a,
  output logic [8*BEAT_BYTES-1:0] ram_d,
  output logic                    busy,
  output logic                    done,
  output logic                    core_en,
  output logic [ASZ-1:0]          cold_p,
  output logic                    chk_err
);

  localparam int N   = (ROM_SZ + BEAT_BYTES - 1) / BEAT_BYTES;
  localparam int KW  = $clog2(N + 1);
  localparam int WW  = (ROM_WAIT > 0) ? $clog2(ROM_WAIT + 1) : 1;
  localparam int REM = ROM_SZ % BEAT_BYTES;
  localparam logic [BEAT_BYTES-1:0] LAST_WM = (REM == 0) ? '1 : BEAT_BYTES'((1 << REM) - 1);

  typedef enum logic [1:0] {S_WAIT, S_COPY, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic          vld;
    logic [KW-1:0] idx;
  } beat_t;

  state_e        state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  beat_t         pipe_q [RD_LAT];
  beat_t         pipe_d [RD_LAT];
  beat_t         wr;
  logic          issue, inflight, wr_last;

`ifdef BOOT_CHKSUM_EN
  logic [31:0] sum_q, sum_d, wr_sum;
  logic        chk_err_q, chk_err_d;
`endif

  // The delay line's last stage is the write stage; earlier stages are reads still in the ROM.
  assign wr      = pipe_q[RD_LAT-1];
  assign issue   = (state_q == S_COPY);
  assign wr_last = (wr.idx == KW'(N - 1));

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) inflight = inflight | pipe_q[i].vld;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_WAIT;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        S_WAIT:  if (cnt_q == '0)         state_d = S_COPY;
        S_COPY:  if (k_q == KW'(N - 1))   state_d = S_DRAIN;
        S_DRAIN: if (!inflight)           state_d = S_DONE;
        S_DONE:  if (start)               state_d = S_WAIT;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != S_DONE);
    done    = (state_q == S_DONE);
    rom_en  = ((state_q == S_COPY) || (state_q == S_DRAIN)) && !hold;
    core_en = done && !chk_err;
  end

  always_comb begin
    cnt_d  = cnt_q;
    k_d    = k_q;
    pipe_d = pipe_q;
`ifdef BOOT_CHKSUM_EN
    sum_d     = sum_q;
    chk_err_d = chk_err_q;
`endif
    if (!hold) begin
      if ((state_q == S_WAIT) && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
      pipe_d[0].vld = issue;
      pipe_d[0].idx = issue ? k_q : '0;
      for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
      if (issue) k_d = k_q + 1'b1;
`ifdef BOOT_CHKSUM_EN
      sum_d = sum_q + wr_sum;
      if ((state_q == S_DRAIN) && !inflight) chk_err_d = (sum_d != CHK_EXP);
`endif
      if ((state_q == S_DONE) && start) begin
        cnt_d = WW'(ROM_WAIT);
        k_d   = '0;
`ifdef BOOT_CHKSUM_EN
        sum_d     = '0;
        chk_err_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= WW'(ROM_WAIT);
      k_q   <= '0;
      // NOTE: the delay line is a handful of flops whose valid bits define state, so it is reset.
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
`ifdef BOOT_CHKSUM_EN
      sum_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      k_q    <= k_d;
      pipe_q <= pipe_d;
`ifdef BOOT_CHKSUM_EN
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  // ram_d follows the ROM output register directly; bytes past the image end are zeroed.
  always_comb begin
    ram_wm = '0;
    ram_d  = '0;
    if (wr.vld) ram_wm = wr_last ? LAST_WM : '1;
    for (int b = 0; b < BEAT_BYTES; b++)
      if (ram_wm[b]) ram_d[8*b +: 8] = rom_d[8*b +: 8];
  end

  assign ram_we = wr.vld & ~hold;
  assign ram_a  = RAM_BASE + ASZ'(wr.idx) * ASZ'(BEAT_BYTES);
  assign rom_a  = ASZ'(k_q) * ASZ'(BEAT_BYTES);
  assign cold_p = COLD;

`ifdef BOOT_CHKSUM_EN
  always_comb begin
    wr_sum = '0;
    for (int b = 0; b < BEAT_BYTES; b++) wr_sum = wr_sum + 32'(ram_d[8*b +: 8]);
  end
  assign chk_err = chk_err_q;
`else
  // Checksum disabled: the flag is constant low.
  assign chk_err = 1'b0 & ^CHK_EXP;
`endif

endmodule

// File: tb/tb_ej32_boot_loader.sv
// Self-checking bench: three loader configurations share random rst/hold/start and are
// compared every cycle against a timing/content model derived from the loader's rules.
module tb_ej32_boot_loader;

  localparam int ASZ = 17;
  localparam int NC  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hold, start;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [NC-1:0] done_vec;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ROM image content; also defined past the image end so masking is observable.
  function automatic logic [7:0] rom_byte(int g, int i);
    return (g == 0) ? 8'(i) : 8'((i * 37 + g * 11) % 256);
  endfunction

  function automatic int img_sum(int g, int sz);
    int s = 0;
    for (int i = 0; i < sz; i++) s += int'(rom_byte(g, i));
    return s;
  endfunction

  // Little-endian beat of bytes starting at a; bytes at or beyond lim read as zero.
  function automatic logic [31:0] rom_word(int g, int bb, int a, int lim);
    logic [31:0] w = '0;
    for (int i = 0; i < bb; i++)
      if (a + i < lim) w[8*i +: 8] = rom_byte(g, a + i);
    return w;
  endfunction

  for (genvar g = 0; g < NC; g++) begin : g_inst
    localparam int BB = (g == 0) ? 1  : (g == 1) ? 4  : 2;
    localparam int SZ = (g == 0) ? 16 : (g == 1) ? 10 : 7;
    localparam int W  = (g == 0) ? 3  : (g == 1) ? 2  : 0;
    localparam int L  = (g == 0) ? 1  : (g == 1) ? 2  : 3;
    localparam logic [ASZ-1:0] BASE = (g == 0) ? 17'h0 : (g == 1) ? 17'h100 : 17'h1FFFC;
    localparam logic [ASZ-1:0] CP   = (g == 0) ? 17'h0 : (g == 1) ? 17'h20  : 17'h1234;
    localparam int SUM = img_sum(g, SZ);
    localparam logic [31:0] EXP = (g == 0) ? 32'd120 : (g == 1) ? 32'(SUM) : 32'(SUM + 1);
    localparam int N        = (SZ + BB - 1) / BB;
    localparam int FIRST_WR = W + 1 + L;
    localparam int DONE_AT  = W + N + L + 1;
`ifdef BOOT_CHKSUM_EN
    localparam bit EXP_ERR = (32'(SUM) != EXP);
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic              rom_en, ram_we, busy, done, core_en, chk_err;
    logic [ASZ-1:0]    rom_a, ram_a, cold_p;
    logic [8*BB-1:0]   rom_d, ram_d;
    logic [BB-1:0]     ram_wm;
    logic [8*BB-1:0]   rom_pipe [L];
    logic [31:0]       rom_word_w;

    ej32_boot_loader #(
      .ASZ(ASZ), .BEAT_BYTES(BB), .ROM_SZ(SZ), .ROM_WAIT(W), .RD_LAT(L),
      .RAM_BASE(BASE), .COLD(CP), .CHK_EXP(EXP)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .rom_en(rom_en), .rom_a(rom_a), .rom_d(rom_d),
      .ram_we(ram_we), .ram_wm(ram_wm), .ram_a(ram_a), .ram_d(ram_d),
      .busy(busy), .done(done), .core_en(core_en), .cold_p(cold_p), .chk_err(chk_err)
    );

    // ROM with an L-stage output pipeline, advanced only while rom_en is high.
    assign rom_word_w = rom_word(g, BB, int'(rom_a), 32'h7fffffff);
    always @(posedge clk) begin
      if (rom_en) begin
        for (int i = L - 1; i > 0; i--) rom_pipe[i] <= rom_pipe[i-1];
        rom_pipe[0] <= rom_word_w[8*BB-1:0];
      end
    end
    assign rom_d = rom_pipe[L-1];
    assign done_vec[g] = done;

    // Model: number of unheld edges since reset/re-boot fixes every expected output.
    int a_m = 0;
    always @(posedge clk) begin
      if (!rst)                          a_m <= 0;
      else if (hold)                     a_m <= a_m;
      else if (start && a_m >= DONE_AT)  a_m <= 0;
      else if (a_m < 1000000)            a_m <= a_m + 1;
    end

    int wr_cnt = 0;
    bit cnt_done = 1'b0;
    always @(negedge clk) begin
      int             k;
      bit             in_wr, exp_done, exp_err;
      logic [ASZ-1:0] exp_a;
      logic [31:0]    exp_w;
      logic [3:0]     exp_m;
      k        = a_m - FIRST_WR;
      in_wr    = (a_m >= FIRST_WR) && (a_m < DONE_AT);
      exp_done = (a_m >= DONE_AT);
      exp_err  = exp_done && EXP_ERR;
      if (a_m == 0) begin
        wr_cnt   = 0;
        cnt_done = 1'b0;
      end
      if (ram_we) wr_cnt++;

      check($sformatf("c%0d.done", g), done, exp_done);
      check($sformatf("c%0d.busy", g), busy, !exp_done);
      check($sformatf("c%0d.chk_err", g), chk_err, exp_err);
      check($sformatf("c%0d.core_en", g), core_en, exp_done && !exp_err);
      check($sformatf("c%0d.cold_p", g), cold_p, CP);
      check($sformatf("c%0d.ram_we", g), ram_we, in_wr && !hold);
      check($sformatf("c%0d.rom_en", g), rom_en, !hold && (a_m >= W + 1) && (a_m < DONE_AT));
      if ((a_m >= W + 1) && (a_m <= W + N))
        check($sformatf("c%0d.rom_a", g), rom_a, ASZ'((a_m - W - 1) * BB));
      if (in_wr && !hold) begin
        exp_a = BASE + ASZ'(k * BB);
        exp_w = rom_word(g, BB, k * BB, SZ);
        exp_m = '0;
        for (int i = 0; i < BB; i++) exp_m[i] = (k * BB + i < SZ);
        check($sformatf("c%0d.ram_a[%0d]", g, k), ram_a, exp_a);
        check($sformatf("c%0d.ram_d[%0d]", g, k), ram_d, exp_w[8*BB-1:0]);
        check($sformatf("c%0d.ram_wm[%0d]", g, k), ram_wm, exp_m[BB-1:0]);
      end
      if (exp_done && !cnt_done) begin
        check($sformatf("c%0d.writes", g), wr_cnt, N);
        cnt_done = 1'b1;
      end
    end
  end

  task automatic drive(input logic r, input logic h, input logic s);
    rst   = r;
    hold  = h;
    start = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic r, h, s;
    rst = 1'b0; hold = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Clean boot of every configuration.
    repeat (40) drive(1'b1, 1'b0, 1'b0);

    // Re-boot, then hold 4 cycles from the first write of config 0; a mid-copy start follows.
    drive(1'b1, 1'b0, 1'b1);
    repeat (5) drive(1'b1, 1'b0, 1'b0);
    repeat (4) drive(1'b1, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    repeat (40) drive(1'b1, 1'b0, 1'b0);

    // Re-boot, then a one-cycle reset right after config 0's eighth write.
    drive(1'b1, 1'b0, 1'b1);
    repeat (13) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (40) drive(1'b1, 1'b0, 1'b0);

    // Random rst/hold/start traffic.
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) != 0);
      h = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 9) == 0);
      drive(r, h, s);
    end

    // Bounded wait for every configuration to finish.
    for (int i = 0; i < 200 && done_vec != {NC{1'b1}}; i++) drive(1'b1, 1'b0, 1'b0);
    check("final_done", done_vec, {NC{1'b1}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
